// File: rtl/alu_mem_connection_test.sv
// Execute-to-memory backend slice: EX/MEM register, word-addressed data memory
// and MEM/WB register, with a fixed two-edge latency from inputs to outputs.
module alu_mem_connection_test #(
  parameter int DATA_W = 24,
  parameter int DEST_W = 4,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              writeback_enable,
  input  logic              mem_read_enable,
  input  logic              mem_write_enable,
  input  logic [DEST_W-1:0] instruction_dest,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] write_data,
  output logic              writeback_enable_out,
  output logic              mem_read_enable_out,
  output logic [DEST_W-1:0] instruction_dest_out,
  output logic [DATA_W-1:0] memory_out,
  output logic [DATA_W-1:0] alu_result_out
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic              ex_wb_en_q,  ex_wb_en_d;
  logic              ex_rd_en_q,  ex_rd_en_d;
  logic              ex_wr_en_q,  ex_wr_en_d;
  logic [DEST_W-1:0] ex_dest_q,   ex_dest_d;
  logic [DATA_W-1:0] ex_alu_q,    ex_alu_d;
  logic [DATA_W-1:0] ex_wdata_q,  ex_wdata_d;

  logic              wb_en_q,     wb_en_d;
  logic              wb_rd_en_q,  wb_rd_en_d;
  logic [DEST_W-1:0] wb_dest_q,   wb_dest_d;
  logic [DATA_W-1:0] wb_alu_q,    wb_alu_d;
  logic [DATA_W-1:0] wb_mem_q,    wb_mem_d;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  logic [ADDR_W-1:0] addr_s;
  logic [DATA_W-1:0] rdata_s;

  // Upper address bits are dropped, so accesses wrap modulo the memory depth.
  assign addr_s  = ex_alu_q[ADDR_W-1:0];
  assign rdata_s = mem_q[addr_s];

  // Next-state for both pipeline registers; the read uses the pre-write word.
  always_comb begin
    ex_wb_en_d = writeback_enable;
    ex_rd_en_d = mem_read_enable;
    ex_wr_en_d = mem_write_enable;
    ex_dest_d  = instruction_dest;
    ex_alu_d   = alu_result;
    ex_wdata_d = write_data;

    wb_en_d    = ex_wb_en_q;
    wb_rd_en_d = ex_rd_en_q;
    wb_dest_d  = ex_dest_q;
    wb_alu_d   = ex_alu_q;
    if (ex_rd_en_q) begin
      wb_mem_d = rdata_s;
    end else begin
      wb_mem_d = {DATA_W{1'b0}};
    end
  end

  // Memory next-state: one word may be replaced by the registered store.
  always_comb begin
    mem_d = mem_q;
    if (ex_wr_en_q) begin
      mem_d[addr_s] = ex_wdata_q;
    end else begin
      mem_d[addr_s] = mem_q[addr_s];
    end
  end

  // Pipeline registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_wb_en_q <= 1'b0;
      ex_rd_en_q <= 1'b0;
      ex_wr_en_q <= 1'b0;
      ex_dest_q  <= {DEST_W{1'b0}};
      ex_alu_q   <= {DATA_W{1'b0}};
      ex_wdata_q <= {DATA_W{1'b0}};
      wb_en_q    <= 1'b0;
      wb_rd_en_q <= 1'b0;
      wb_dest_q  <= {DEST_W{1'b0}};
      wb_alu_q   <= {DATA_W{1'b0}};
      wb_mem_q   <= {DATA_W{1'b0}};
    end else begin
      ex_wb_en_q <= ex_wb_en_d;
      ex_rd_en_q <= ex_rd_en_d;
      ex_wr_en_q <= ex_wr_en_d;
      ex_dest_q  <= ex_dest_d;
      ex_alu_q   <= ex_alu_d;
      ex_wdata_q <= ex_wdata_d;
      wb_en_q    <= wb_en_d;
      wb_rd_en_q <= wb_rd_en_d;
      wb_dest_q  <= wb_dest_d;
      wb_alu_q   <= wb_alu_d;
      wb_mem_q   <= wb_mem_d;
    end
  end

  // Data memory; reset clears every word and blocks writes while held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {DATA_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign writeback_enable_out = wb_en_q;
  assign mem_read_enable_out  = wb_rd_en_q;
  assign instruction_dest_out = wb_dest_q;
  assign memory_out           = wb_mem_q;
  assign alu_result_out       = wb_alu_q;

endmodule

// File: tb/tb_alu_mem_connection_test.sv
// Self-checking bench: directed test-plan sequences plus random instructions
// compared against a sequential-program reference model of the memory.
module tb_alu_mem_connection_test;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        writeback_enable = 1'b0;
  logic        mem_read_enable = 1'b0;
  logic        mem_write_enable = 1'b0;
  logic [3:0]  instruction_dest = 4'h0;
  logic [23:0] alu_result = 24'h0;
  logic [23:0] write_data = 24'h0;
  logic        writeback_enable_out;
  logic        mem_read_enable_out;
  logic [3:0]  instruction_dest_out;
  logic [23:0] memory_out;
  logic [23:0] alu_result_out;

  alu_mem_connection_test dut (
    .clk                  (clk),
    .rst                  (rst),
    .writeback_enable     (writeback_enable),
    .mem_read_enable      (mem_read_enable),
    .mem_write_enable     (mem_write_enable),
    .instruction_dest     (instruction_dest),
    .alu_result           (alu_result),
    .write_data           (write_data),
    .writeback_enable_out (writeback_enable_out),
    .mem_read_enable_out  (mem_read_enable_out),
    .instruction_dest_out (instruction_dest_out),
    .memory_out           (memory_out),
    .alu_result_out       (alu_result_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        wb;
    logic        rd;
    logic [3:0]  dest;
    logic [23:0] mem;
    logic [23:0] alu;
  } exp_t;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [23:0] ref_mem [256];
  exp_t        prev_exp;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag, input exp_t e);
    check_val({tag, ".wb"},   {31'd0, writeback_enable_out}, {31'd0, e.wb});
    check_val({tag, ".rd"},   {31'd0, mem_read_enable_out},  {31'd0, e.rd});
    check_val({tag, ".dest"}, {28'd0, instruction_dest_out}, {28'd0, e.dest});
    check_val({tag, ".mem"},  {8'd0, memory_out},            {8'd0, e.mem});
    check_val({tag, ".alu"},  {8'd0, alu_result_out},        {8'd0, e.alu});
  endtask

  // Model: instructions execute in program order; load sees memory before its own store.
  task automatic send(input logic wb, input logic rd, input logic wr, input logic [3:0] dest,
                      input logic [23:0] alu, input logic [23:0] wd);
    exp_t cur;
    int   idx;
    writeback_enable = wb;
    mem_read_enable  = rd;
    mem_write_enable = wr;
    instruction_dest = dest;
    alu_result       = alu;
    write_data       = wd;
    idx      = int'(alu) % 256;
    cur.wb   = wb;
    cur.rd   = rd;
    cur.dest = dest;
    cur.alu  = alu;
    cur.mem  = rd ? ref_mem[idx] : 24'h0;
    if (wr) ref_mem[idx] = wd;
    @(posedge clk);
    @(negedge clk);
    check_all("pipe", prev_exp);
    prev_exp = cur;
  endtask

  task automatic idle();
    send(1'b0, 1'b0, 1'b0, 4'h0, 24'h0, 24'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check_all("async_rst", '0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 24'h0;
    prev_exp = '0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = 24'h0;
    prev_exp = '0;
    #1 check_all("reset_state", '0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Pass-through
    send(1'b1, 1'b0, 1'b0, 4'h1, 24'h00ABCD, 24'h0);
    idle();
    check_val("pt.wb",   {31'd0, writeback_enable_out}, 32'd1);
    check_val("pt.dest", {28'd0, instruction_dest_out}, 32'd1);
    check_val("pt.alu",  {8'd0, alu_result_out},        32'h00ABCD);
    check_val("pt.mem",  {8'd0, memory_out},            32'd0);

    // Store then load
    send(1'b0, 1'b0, 1'b1, 4'h0, 24'd5, 24'h123456);
    send(1'b1, 1'b1, 1'b0, 4'h2, 24'd5, 24'h0);
    idle();
    check_val("sl.mem", {8'd0, memory_out},           32'h123456);
    check_val("sl.rd",  {31'd0, mem_read_enable_out}, 32'd1);

    // Address wrap
    send(1'b0, 1'b0, 1'b1, 4'h0, 24'h000103, 24'hAAAAAA);
    send(1'b1, 1'b1, 1'b0, 4'h3, 24'd3, 24'h0);
    idle();
    check_val("wrap.mem", {8'd0, memory_out}, 32'hAAAAAA);

    // Back-to-back loads
    send(1'b0, 1'b0, 1'b1, 4'h0, 24'd1, 24'h11);
    send(1'b0, 1'b0, 1'b1, 4'h0, 24'd2, 24'h22);
    send(1'b1, 1'b1, 1'b0, 4'h4, 24'd1, 24'h0);
    send(1'b1, 1'b1, 1'b0, 4'h5, 24'd2, 24'h0);
    check_val("b2b1.mem", {8'd0, memory_out},     32'h11);
    check_val("b2b1.alu", {8'd0, alu_result_out}, 32'd1);
    idle();
    check_val("b2b2.mem", {8'd0, memory_out},     32'h22);
    check_val("b2b2.alu", {8'd0, alu_result_out}, 32'd2);

    // Simultaneous read+write returns the old word
    send(1'b0, 1'b0, 1'b1, 4'h0, 24'd7, 24'h000007);
    send(1'b1, 1'b1, 1'b1, 4'h6, 24'd7, 24'hFFFFFF);
    idle();
    check_val("rw.old", {8'd0, memory_out}, 32'h000007);
    send(1'b1, 1'b1, 1'b0, 4'h7, 24'd7, 24'h0);
    idle();
    check_val("rw.new", {8'd0, memory_out}, 32'hFFFFFF);

    // Mid-run reset with non-zero inputs in flight, then memory must read 0
    send(1'b1, 1'b1, 1'b1, 4'hF, 24'd5, 24'h654321);
    writeback_enable = 1'b1;
    mem_read_enable  = 1'b1;
    mem_write_enable = 1'b1;
    instruction_dest = 4'hA;
    alu_result       = 24'd7;
    write_data       = 24'h777777;
    do_reset();
    send(1'b1, 1'b1, 1'b0, 4'h2, 24'd5, 24'h0);
    idle();
    check_val("rst.load5", {8'd0, memory_out}, 32'd0);

    // Random instructions, addresses concentrated on a small window to force reuse
    for (int n = 0; n < 400; n++) begin
      logic [23:0] a;
      a = {$urandom_range(0, 3) == 0 ? 16'($urandom) : 16'h0, 8'($urandom_range(0, 15))};
      send(1'($urandom), 1'($urandom), 1'($urandom), 4'($urandom), a, 24'($urandom));
      if (n == 200) do_reset();
    end
    idle();
    idle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
